// File: rtl/lsu_stage_pkg.sv
// Shared types for the load/store stage: EXU->LSU and LSU->WBU payloads,
// load/store width encodings, LSU FSM states and the alignment predicate.
package lsu_stage_pkg;

   localparam int unsigned XLEN = 32;

   // funct3 width encodings shared by loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Payload from EXU
   typedef struct packed {
      logic [XLEN-1:0] pc_target;
      logic            reg_wen;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] exu_result;
      logic            mem_en;
      logic            mem_wen;
      logic [2:0]      funct3;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN-1:0] rs2_data;
   } ex_lsu_t;

   // Payload to WBU
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc_target;
      logic            reg_wen;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] wb_data;
   } lsu_wb_t;

   // Fields of the accepted instruction still needed after the request issues
   typedef struct packed {
      logic [XLEN-1:0] pc_target;
      logic            reg_wen;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] exu_result;
      logic            mem_wen;
      logic [2:0]      funct3;
      logic [1:0]      offset;
   } lsu_ctx_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_RESP    = 2'd2,
      S_WAIT_WB = 2'd3
   } lsu_state_e;

   // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_H, F3_HU: return off[0];
         F3_W:        return (off != 2'b00);
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper for the LSU (combinational).
// Store side: replicates store data across lanes and builds byte strobes.
// Load side: shifts the response word by the byte offset, then sign/zero extends.
// Ports:
//   i_st_funct3/i_st_offset/i_st_data -> o_wdata_c, o_wstrb_c
//   i_ld_funct3/i_ld_offset/i_rdata   -> o_ld_data_c
module lsu_align
   import lsu_stage_pkg::*;
(
   input  logic [2:0]  i_st_funct3,
   input  logic [1:0]  i_st_offset,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_wdata_c,
   output logic [3:0]  o_wstrb_c,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_offset,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data_c
);

   logic [31:0] w_sh;

   // Store lanes; the halfword strobe shift drops bits past lane 3
   always_comb begin
      o_wdata_c = i_st_data;
      o_wstrb_c = 4'b1111;
      case (i_st_funct3)
         F3_B: begin
            o_wdata_c = {4{i_st_data[7:0]}};
            o_wstrb_c = 4'b0001 << i_st_offset;
         end
         F3_H: begin
            o_wdata_c = {2{i_st_data[15:0]}};
            o_wstrb_c = 4'b0011 << i_st_offset;
         end
         default: ;
      endcase
   end

   assign w_sh = i_rdata >> {i_ld_offset, 3'b000};

   // Load extract and extend
   always_comb begin
      o_ld_data_c = i_rdata;
      case (i_ld_funct3)
         F3_B:    o_ld_data_c = {{24{w_sh[7]}}, w_sh[7:0]};
         F3_H:    o_ld_data_c = {{16{w_sh[15]}}, w_sh[15:0]};
         F3_W:    o_ld_data_c = w_sh;
         F3_BU:   o_ld_data_c = {24'd0, w_sh[7:0]};
         F3_HU:   o_ld_data_c = {16'd0, w_sh[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage between EXU and WBU.
// Non-memory instructions go straight to write-back; loads/stores issue one
// request on the data-memory port and wait for its response. One instruction
// is in flight at a time; all handshake outputs are registered state decodes.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned H/W accesses skip memory,
// write back with reg_wen=0 and pulse lsu_misalign for one cycle.
// Ports:
//   clk, rst (async, active-high)
//   lsu_in_valid/lsu_in_ready/lsu_in_payload     : from EXU (ex_lsu_t)
//   lsu_out_valid/lsu_out_ready/lsu_out_payload  : to WBU (lsu_wb_t)
//   dmem_req_*  : request (word address, wen, lane data, strobes)
//   dmem_resp_* : response (valid/ready, read word)
//   lsu_misalign: misalignment pulse (macro builds only)
module lsu_stage
   import lsu_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lsu_in_valid,
   output logic                lsu_in_ready,
   input  ex_lsu_t             lsu_in_payload,
   output logic                lsu_out_valid,
   input  logic                lsu_out_ready,
   output lsu_wb_t             lsu_out_payload,
   output logic                dmem_req_valid,
   input  logic                dmem_req_ready,
   output logic [ADDR_W-1:0]   dmem_req_addr,
   output logic                dmem_req_wen,
   output logic [DATA_W-1:0]   dmem_req_wdata,
   output logic [DATA_W/8-1:0] dmem_req_wstrb,
   input  logic                dmem_resp_valid,
   output logic                dmem_resp_ready,
   input  logic [DATA_W-1:0]   dmem_resp_rdata
`ifdef LSU_MISALIGN_CHECK_EN
   ,
   output logic                lsu_misalign
`endif
);

   localparam int unsigned STRB_W = DATA_W / 8;

   lsu_state_e          r_state;
   lsu_state_e          w_state_n;
   lsu_ctx_t            r_ctx;
   lsu_wb_t             r_out;
   lsu_wb_t             w_wb_n;
   logic                r_in_ready;
   logic                r_req_valid;
   logic                r_resp_ready;
   logic                r_out_valid;
   logic [ADDR_W-1:0]   r_req_addr;
   logic                r_req_wen;
   logic [DATA_W-1:0]   r_req_wdata;
   logic [STRB_W-1:0]   r_req_wstrb;
   logic                w_in_fire;
   logic                w_mis;
   logic [31:0]         w_wdata;
   logic [3:0]          w_wstrb;
   logic [31:0]         w_ld_data;

   assign w_in_fire = lsu_in_valid && r_in_ready;

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_mis = lsu_in_payload.mem_en &&
                  is_misaligned(lsu_in_payload.funct3, lsu_in_payload.mem_addr[1:0]);
`else
   assign w_mis = 1'b0;
`endif

   // Store lanes come from the incoming payload, load extract from the held context
   lsu_align u_align (
      .i_st_funct3 (lsu_in_payload.funct3),
      .i_st_offset (lsu_in_payload.mem_addr[1:0]),
      .i_st_data   (lsu_in_payload.rs2_data),
      .o_wdata_c   (w_wdata),
      .o_wstrb_c   (w_wstrb),
      .i_ld_funct3 (r_ctx.funct3),
      .i_ld_offset (r_ctx.offset),
      .i_rdata     (32'(dmem_resp_rdata)),
      .o_ld_data_c (w_ld_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   // Next state and next write-back payload
   always_comb begin
      w_state_n = r_state;
      w_wb_n    = r_out;
      case (r_state)
         S_IDLE: begin
            if (w_in_fire) begin
               if (lsu_in_payload.mem_en && !w_mis) begin
                  w_state_n = S_REQ;
               end else begin
                  w_state_n        = S_WAIT_WB;
                  w_wb_n.valid     = 1'b1;
                  w_wb_n.pc_target = lsu_in_payload.pc_target;
                  w_wb_n.rd_addr   = lsu_in_payload.rd_addr;
                  w_wb_n.reg_wen   = lsu_in_payload.reg_wen && !w_mis &&
                                     !(lsu_in_payload.mem_en && lsu_in_payload.mem_wen);
                  w_wb_n.wb_data   = lsu_in_payload.exu_result;
               end
            end
         end
         S_REQ: begin
            if (dmem_req_ready) w_state_n = S_RESP;
         end
         S_RESP: begin
            if (dmem_resp_valid) begin
               w_state_n        = S_WAIT_WB;
               w_wb_n.valid     = 1'b1;
               w_wb_n.pc_target = r_ctx.pc_target;
               w_wb_n.rd_addr   = r_ctx.rd_addr;
               w_wb_n.reg_wen   = r_ctx.reg_wen && !r_ctx.mem_wen;
               w_wb_n.wb_data   = r_ctx.mem_wen ? r_ctx.exu_result : w_ld_data;
            end
         end
         S_WAIT_WB: begin
            if (lsu_out_ready) begin
               w_state_n    = S_IDLE;
               w_wb_n.valid = 1'b0;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Registered state decodes, captured context and request fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_ready   <= 1'b1;
         r_req_valid  <= 1'b0;
         r_resp_ready <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out        <= '0;
         r_ctx        <= '0;
         r_req_addr   <= '0;
         r_req_wen    <= 1'b0;
         r_req_wdata  <= '0;
         r_req_wstrb  <= '0;
      end else begin
         r_in_ready   <= (w_state_n == S_IDLE);
         r_req_valid  <= (w_state_n == S_REQ);
         r_resp_ready <= (w_state_n == S_RESP);
         r_out_valid  <= (w_state_n == S_WAIT_WB);
         r_out        <= w_wb_n;
         if (w_in_fire) begin
            r_ctx.pc_target  <= lsu_in_payload.pc_target;
            r_ctx.reg_wen    <= lsu_in_payload.reg_wen;
            r_ctx.rd_addr    <= lsu_in_payload.rd_addr;
            r_ctx.exu_result <= lsu_in_payload.exu_result;
            r_ctx.mem_wen    <= lsu_in_payload.mem_wen;
            r_ctx.funct3     <= lsu_in_payload.funct3;
            r_ctx.offset     <= lsu_in_payload.mem_addr[1:0];
            r_req_addr       <= ADDR_W'({lsu_in_payload.mem_addr[31:2], 2'b00});
            r_req_wen        <= lsu_in_payload.mem_wen;
            r_req_wdata      <= DATA_W'(w_wdata);
            r_req_wstrb      <= lsu_in_payload.mem_wen ? STRB_W'(w_wstrb) : '0;
         end
      end
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic r_misalign;

   // High for the first write-back cycle of a skipped access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_misalign <= 1'b0;
      else     r_misalign <= (r_state == S_IDLE) && w_in_fire && w_mis;
   end

   assign lsu_misalign = r_misalign;
`endif

   assign lsu_in_ready    = r_in_ready;
   assign lsu_out_valid   = r_out_valid;
   assign lsu_out_payload = r_out;
   assign dmem_req_valid  = r_req_valid;
   assign dmem_req_addr   = r_req_addr;
   assign dmem_req_wen    = r_req_wen;
   assign dmem_req_wdata  = r_req_wdata;
   assign dmem_req_wstrb  = r_req_wstrb;
   assign dmem_resp_ready = r_resp_ready;

endmodule
